instr_cycle_sequencer: RTL and testbench
========================================

Name: instr_cycle_sequencer

Overview:
- Timing and control sequencer for the basic computer. It is the driving end of the per-register control interface: it generates the clear, load and increment strobes that the single-bit and multi-bit registers consume.
- Contains the run flip-flop S, the sequence counter SC and its one-hot timing decode, and a registered opcode decode.
- Issues the fixed fetch/decode/indirect micro-operation strobes and tells the execution logic when its phase begins.

Parameters:
SC_WIDTH, 3, sequence counter width; timing outputs are 2**SC_WIDTH wide (T0..T7).
OPC_WIDTH, 3, opcode field width; decode outputs are 2**OPC_WIDTH wide (D0..D7).

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset_sc  input  1  synchronous, active-high reset
start  input  1  sets S (run)
halt  input  1  HLT from execution logic; clears S
sc_clr  input  1  end-of-instruction from execution logic; clears SC
ir_opcode  input  OPC_WIDTH  IR[14:12], valid from T2
ir_i  input  1  IR[15] indirect bit, valid from T2
run  output  1  S flag
timing  output  2**SC_WIDTH  one-hot T-states, all zero when run=0
decode  output  2**OPC_WIDTH  one-hot registered opcode decode
ind  output  1  latched I bit
ar_load_pc  output  1  AR<-PC
pc_inc  output  1  PC<-PC+1
mem_read  output  1  memory read enable
ir_load  output  1  IR<-M[AR]
ar_load_ir  output  1  AR<-IR[11:0]
ar_load_mem  output  1  AR<-M[AR] (indirect)
exec_mem  output  1  memory-reference execute window
exec_rio  output  1  register/IO execute step
seq_err  output  1  sticky SC wrap error

Behaviour:
- Reset (reset_sc=1 at an edge), with priority over everything:
  - S=0, SC=0, opcode register=0, I register=0, seq_err=0.
  - Therefore decode=D0 one-hot, ind=0 and every strobe is 0.
- S update, priority order:
  - reset;
  - halt sets S=0 and also SC=0;
  - start sets S=1.
  - start and halt in the same cycle gives S=0.
- SC update, priority order:
  - reset;
  - halt, or sc_clr, sets SC=0. sc_clr is honoured even when run=0.
  - run=1 increments SC by 1, modulo 2**SC_WIDTH.
  - run=0 holds SC.
- Wrap: an increment from 7 to 0 without sc_clr sets seq_err=1. seq_err stays set until reset.
- timing[k] = run & (SC==k). This is combinational from registered state.
- Opcode and I capture:
  - Registered on the edge ending T2 (run & SC==2).
  - decode = one-hot of the registered opcode; ind = the registered I bit.
  - Both are valid from T3 and hold until the next T2 capture or reset.
- Strobes (combinational, all gated by run):
  - T0: ar_load_pc.
  - T1: mem_read, ir_load, pc_inc.
  - T2: ar_load_ir.
  - T3 with ~D7 and ind: ar_load_mem and mem_read.
  - T3 with ~D7 and ~ind: no fetch strobes.
  - exec_mem = run & ~D7 & (SC>=4).
  - exec_rio = run & D7 & T3.
- Latency:
  - start asserted in cycle n gives T0 in cycle n+1.
  - sc_clr asserted during Tk gives T0 in the next cycle.
- halt asserted mid-fetch: the next cycle shows run=0 and all strobes 0. The opcode and I registers keep their values.
- Reset mid-instruction: back to the idle state in the next cycle; no strobe is asserted in that cycle.

Test Plan:
- Reset then idle: reset_sc=1 for 1 cycle, then 5 idle cycles -> run=0, timing=0, decode=8'h01, all strobes 0, seq_err=0.
- Fetch, direct memory-reference:
  - Stimulus: start pulse, ir_opcode=3'b010, ir_i=0 presented from T2.
  - Required response, cycle by cycle:
    - T0: ar_load_pc=1.
    - T1: ir_load=1, mem_read=1, pc_inc=1.
    - T2: ar_load_ir=1.
    - T3: decode=8'h04, no strobes.
    - T4: exec_mem=1.
    - sc_clr at T5 -> T0 next cycle.
- Indirect: ir_opcode=3'b001, ir_i=1 -> at T3 ind=1, ar_load_mem=1, mem_read=1; exec_mem asserted at T4.
- Register/IO: ir_opcode=3'b111 -> at T3 decode=8'h80 and exec_rio=1; exec_mem stays 0 at T4.
- Start and halt together while running at T5 -> next cycle run=0, timing=0; SC is 0 on a subsequent start (T0 first).
- Wrap: run 8 cycles with sc_clr never asserted -> SC returns to T0, seq_err=1 and stays 1; reset_sc clears it to 0.

Source files
------------

// File: rtl/instr_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_cycle_sequencer
// Brief    : Run flag, sequence counter, T-state decode, opcode latch and
//            fetch/decode/indirect control strobes for the basic computer.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cycle_sequencer #(
    parameter int SC_WIDTH  = 3,
    parameter int OPC_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset_sc,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      sc_clr,
    input  logic [OPC_WIDTH-1:0]      ir_opcode,
    input  logic                      ir_i,
    output logic                      run,
    output logic [(2**SC_WIDTH)-1:0]  timing,
    output logic [(2**OPC_WIDTH)-1:0] decode,
    output logic                      ind,
    output logic                      ar_load_pc,
    output logic                      pc_inc,
    output logic                      mem_read,
    output logic                      ir_load,
    output logic                      ar_load_ir,
    output logic                      ar_load_mem,
    output logic                      exec_mem,
    output logic                      exec_rio,
    output logic                      seq_err
);

    localparam int                    c_NUM_T   = 2**SC_WIDTH;
    localparam int                    c_NUM_D   = 2**OPC_WIDTH;
    localparam logic [SC_WIDTH-1:0]   c_SC_MAX  = SC_WIDTH'(c_NUM_T - 1);
    localparam logic [SC_WIDTH-1:0]   c_SC_CAPT = SC_WIDTH'(2);
    localparam logic [SC_WIDTH-1:0]   c_SC_EXEC = SC_WIDTH'(4);
    localparam logic [c_NUM_T-1:0]    c_T_ONE   = c_NUM_T'(1);
    localparam logic [c_NUM_D-1:0]    c_D_ONE   = c_NUM_D'(1);

    logic                 r_s;
    logic [SC_WIDTH-1:0]  r_sc;
    logic [OPC_WIDTH-1:0] r_opc;
    logic                 r_i;
    logic                 r_seq_err;

    logic                 w_d7;
    logic                 w_ind_t3;

    always_ff @(posedge clk) begin
        if (reset_sc) begin
            r_s       <= 1'b0;
            r_sc      <= '0;
            r_opc     <= '0;
            r_i       <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            if (halt)
                r_s <= 1'b0;
            else if (start)
                r_s <= 1'b1;

            if (halt || sc_clr)
                r_sc <= '0;
            else if (r_s)
                r_sc <= r_sc + 1'b1;

            // A counter rolling past the last T-state means the executor never ended the instruction
            if (r_s && !halt && !sc_clr && (r_sc == c_SC_MAX))
                r_seq_err <= 1'b1;

            if (r_s && (r_sc == c_SC_CAPT)) begin
                r_opc <= ir_opcode;
                r_i   <= ir_i;
            end
        end
    end

    always_comb begin
        run     = r_s;
        seq_err = r_seq_err;
        ind     = r_i;
        decode  = c_D_ONE << r_opc;
        timing  = r_s ? (c_T_ONE << r_sc) : '0;
    end

    assign w_d7     = decode[c_NUM_D-1];
    assign w_ind_t3 = timing[3] & ~w_d7 & r_i;

    assign ar_load_pc  = timing[0];
    assign pc_inc      = timing[1];
    assign ir_load     = timing[1];
    assign mem_read    = timing[1] | w_ind_t3;
    assign ar_load_ir  = timing[2];
    assign ar_load_mem = w_ind_t3;
    assign exec_mem    = r_s & ~w_d7 & (r_sc >= c_SC_EXEC);
    assign exec_rio    = timing[3] & w_d7;

endmodule
`default_nettype wire

// File: tb/tb_instr_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_cycle_sequencer
// Brief    : Directed plus random stimulus against a behavioural sequencer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset_sc, start, halt, sc_clr, ir_i;
    logic [2:0] ir_opcode;
    logic       run, ind, ar_load_pc, pc_inc, mem_read, ir_load;
    logic       ar_load_ir, ar_load_mem, exec_mem, exec_rio, seq_err;
    logic [7:0] timing, decode;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: plain integers for the counter and opcode
    bit m_s, m_i, m_err;
    int m_sc, m_opc;

    always #5 clk = ~clk;

    instr_cycle_sequencer #(.SC_WIDTH(3), .OPC_WIDTH(3)) dut (
        .clk(clk), .reset_sc(reset_sc), .start(start), .halt(halt), .sc_clr(sc_clr),
        .ir_opcode(ir_opcode), .ir_i(ir_i), .run(run), .timing(timing), .decode(decode),
        .ind(ind), .ar_load_pc(ar_load_pc), .pc_inc(pc_inc), .mem_read(mem_read),
        .ir_load(ir_load), .ar_load_ir(ar_load_ir), .ar_load_mem(ar_load_mem),
        .exec_mem(exec_mem), .exec_rio(exec_rio), .seq_err(seq_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next-state rules applied with the input values present at the edge
    task automatic model_edge();
        bit cap;
        if (reset_sc) begin
            m_s = 0; m_sc = 0; m_opc = 0; m_i = 0; m_err = 0;
        end else begin
            cap = m_s && (m_sc == 2);
            if (m_s && !halt && !sc_clr && m_sc == 7) m_err = 1;
            if (cap) begin
                m_opc = int'(ir_opcode);
                m_i   = ir_i;
            end
            if (halt || sc_clr) m_sc = 0;
            else if (m_s)       m_sc = (m_sc + 1) % 8;
            if (halt)       m_s = 0;
            else if (start) m_s = 1;
        end
    endtask

    task automatic check_all();
        bit         d7;
        bit [7:0]   et;
        d7 = (m_opc == 7);
        et = m_s ? (8'h01 << m_sc) : 8'h00;
        check_val("run",         run,         m_s);
        check_val("timing",      timing,      et);
        check_val("decode",      decode,      8'h01 << m_opc);
        check_val("ind",         ind,         m_i);
        check_val("ar_load_pc",  ar_load_pc,  et[0]);
        check_val("pc_inc",      pc_inc,      et[1]);
        check_val("ir_load",     ir_load,     et[1]);
        check_val("mem_read",    mem_read,    et[1] | (et[3] & !d7 & m_i));
        check_val("ar_load_ir",  ar_load_ir,  et[2]);
        check_val("ar_load_mem", ar_load_mem, et[3] & !d7 & m_i);
        check_val("exec_mem",    exec_mem,    m_s & !d7 & (m_sc >= 4));
        check_val("exec_rio",    exec_rio,    et[3] & d7);
        check_val("seq_err",     seq_err,     m_err);
    endtask

    task automatic step(input logic st, input logic hl, input logic clr, input logic rs,
                        input logic [2:0] opc, input logic ii);
        start = st; halt = hl; sc_clr = clr; reset_sc = rs; ir_opcode = opc; ir_i = ii;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        start = 0; halt = 0; sc_clr = 0; reset_sc = 0; ir_opcode = 0; ir_i = 0;
        m_s = 0; m_sc = 0; m_opc = 0; m_i = 0; m_err = 0;
        @(negedge clk);

        // Reset then idle
        step(0, 0, 0, 1, 3'd0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 3'd5, 1);
        check_val("idle_decode", decode, 8'h01);
        check_val("idle_timing", timing, 8'h00);

        // Direct memory reference, opcode 2
        step(1, 0, 0, 0, 3'd0, 0);
        check_val("dir_T0_arpc", ar_load_pc, 1'b1);
        step(0, 0, 0, 0, 3'd0, 0);
        check_val("dir_T1_irld", {ir_load, mem_read, pc_inc}, 3'b111);
        step(0, 0, 0, 0, 3'd2, 0);
        check_val("dir_T2_arir", ar_load_ir, 1'b1);
        step(0, 0, 0, 0, 3'd2, 0);
        check_val("dir_T3_dec", decode, 8'h04);
        check_val("dir_T3_strb", {ar_load_mem, mem_read, exec_rio, exec_mem}, 4'b0000);
        step(0, 0, 0, 0, 3'd6, 1);
        check_val("dir_T4_exec", exec_mem, 1'b1);
        step(0, 0, 0, 0, 3'd6, 1);
        step(0, 0, 1, 0, 3'd6, 1);
        check_val("dir_clr_T0", timing, 8'h01);

        // Indirect, opcode 1
        step(0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0, 0, 3'd1, 1);
        step(0, 0, 0, 0, 3'd1, 1);
        check_val("ind_T3", {ind, ar_load_mem, mem_read}, 3'b111);
        step(0, 0, 0, 0, 3'd0, 0);
        check_val("ind_T4_exec", exec_mem, 1'b1);
        step(0, 0, 1, 0, 3'd0, 0);

        // Register/IO, opcode 7
        step(0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0, 0, 3'd7, 0);
        step(0, 0, 0, 0, 3'd7, 0);
        check_val("rio_T3_dec", decode, 8'h80);
        check_val("rio_T3_exec", exec_rio, 1'b1);
        step(0, 0, 0, 0, 3'd0, 0);
        check_val("rio_T4_nomem", exec_mem, 1'b0);

        // Start and halt together at T5
        step(0, 0, 0, 0, 3'd0, 0);
        check_val("sh_at_T5", timing, 8'h20);
        step(1, 1, 0, 0, 3'd0, 0);
        check_val("sh_run", run, 1'b0);
        check_val("sh_timing", timing, 8'h00);
        step(0, 0, 0, 0, 3'd0, 0);
        step(1, 0, 0, 0, 3'd0, 0);
        check_val("sh_restart_T0", timing, 8'h01);

        // Wrap without sc_clr: T0 -> T7 -> T0 sets the sticky error
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 3'd3, 0);
        check_val("wrap_T0", timing, 8'h01);
        check_val("wrap_err", seq_err, 1'b1);
        step(0, 0, 1, 0, 3'd3, 0);
        check_val("wrap_err_sticky", seq_err, 1'b1);
        step(0, 0, 0, 1, 3'd3, 0);
        check_val("wrap_err_rst", seq_err, 1'b0);
        check_val("rst_run", run, 1'b0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 63) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
